// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester-side and FIFO-side handshake bundle for
// fifo_wr_arbiter.
//   in_valid/in_last/in_data/in_ready : NUM_REQ valid/ready/last streams;
//                                       requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_data/out_ready      : FIFO write port (w_valid/w_data/w_ready)
// Modports: master = requesters + FIFO side, slave = arbiter.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            in_valid;
  logic [NUM_REQ-1:0]            in_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]            in_ready;
  logic                          out_valid;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_ready;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-atomic arbiter sharing one async FIFO
// write port among NUM_REQ requesters (single clock domain). A grant is held
// for a whole packet; a beat-count watchdog forces release after MAX_BEATS
// beats without in_last. Output is a single registered beat stage.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : requester streams and FIFO write handshake
//   grant_id     : current or last owner
//   locked       : packet in progress
//   err_timeout  : one-cycle pulse on forced release
//   pkt_count    : (FIFO_ARB_STATS_EN only) 16-bit release counter per
//                  requester, requester i at [i*16 +: 16]
// Optional feature macro: FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  parameter  int MAX_BEATS  = 64,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_wr_arbiter_if.slave    bus,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                locked,
  output logic                err_timeout
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] pkt_count
`endif
);

  localparam int          CNT_W  = $clog2(MAX_BEATS + 1);
  localparam int unsigned NREQ_U = NUM_REQ;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;

  logic                  stage_free;
  logic                  winner_found;
  logic [ID_WIDTH-1:0]   winner;
  logic [ID_WIDTH-1:0]   scan_idx;
  logic [ID_WIDTH-1:0]   owner;
  logic [ID_WIDTH-1:0]   next_rr;
  logic                  take_en;
  logic                  beat_acc;
  logic                  beat_last;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [NUM_REQ-1:0]    in_ready_c;

  assign stage_free = !out_valid_r || bus.out_ready;

  // Round-robin search starting at rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    winner_found = 1'b0;
    winner       = '0;
    scan_idx     = '0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      scan_idx = ID_WIDTH'((32'(rr_ptr) + k) % NREQ_U);
      if (!winner_found && bus.in_valid[scan_idx]) begin
        winner_found = 1'b1;
        winner       = scan_idx;
      end
    end
  end

  // In LOCKED the owner keeps in_ready even while its in_valid is low, so
  // other requesters can never sneak in mid-packet. Gated by rst_n so that
  // in_ready reads 0 throughout reset.
  always_comb begin
    owner      = (state == S_LOCKED) ? grant_id : winner;
    take_en    = rst_n && stage_free && ((state == S_LOCKED) || winner_found);
    in_ready_c = '0;
    if (take_en) in_ready_c[owner] = 1'b1;
    beat_acc   = take_en && bus.in_valid[owner];
    beat_last  = bus.in_last[owner];
    beat_data  = bus.in_data[owner*DATA_WIDTH +: DATA_WIDTH];
    next_rr    = (owner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] pkt_cnt_q [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pkt_count
    assign pkt_count[g*16 +: 16] = pkt_cnt_q[g];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      grant_id    <= '0;
      locked      <= 1'b0;
      err_timeout <= 1'b0;
`ifdef FIFO_ARB_STATS_EN
      for (int unsigned i = 0; i < NREQ_U; i++) pkt_cnt_q[i] <= '0;
`endif
    end else begin
      err_timeout <= 1'b0;

      if (beat_acc) begin
        out_valid_r <= 1'b1;
        out_data_r  <= beat_data;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end

      if (beat_acc) begin
        // A last beat is always a normal release, even at the beat limit.
        if (beat_last || (state == S_LOCKED && beat_cnt == CNT_W'(MAX_BEATS - 1))
            || (state == S_IDLE && MAX_BEATS == 1)) begin
          state    <= S_IDLE;
          locked   <= 1'b0;
          beat_cnt <= '0;
          rr_ptr   <= next_rr;
          if (!beat_last) err_timeout <= 1'b1;
`ifdef FIFO_ARB_STATS_EN
          pkt_cnt_q[owner] <= pkt_cnt_q[owner] + 16'd1;
`endif
        end else if (state == S_IDLE) begin
          state    <= S_LOCKED;
          locked   <= 1'b1;
          beat_cnt <= CNT_W'(1);
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        if (state == S_IDLE) grant_id <= owner;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter with
// NUM_REQ=4, DATA_WIDTH=8, MAX_BEATS=4. Also checks pkt_count when built
// with FIFO_ARB_STATS_EN.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant_id;
  logic       locked;
  logic       err_timeout;
`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0] pkt_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .MAX_BEATS (MB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .grant_id   (grant_id),
    .locked     (locked),
    .err_timeout(err_timeout)
`ifdef FIFO_ARB_STATS_EN
    ,
    .pkt_count  (pkt_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic set_beat(input int r, input logic [7:0] d, input logic l);
    bus.in_data[r*DW +: DW] = d;
    bus.in_last[r]          = l;
  endtask

  task automatic do_reset;
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    idle_in();
    rst_n = 1'b0;
    bus.in_valid = '1;
    bus.in_last  = '1;
    #12;
    compared++;
    if ({bus.out_valid, bus.out_data, bus.in_ready, grant_id, locked, err_timeout} !== 17'h0) begin
      mismatched++;
      $display("FAIL reset_vals: got v=%b d=%h rdy=%b g=%0d l=%b e=%b want all zero",
               bus.out_valid, bus.out_data, bus.in_ready, grant_id, locked, err_timeout);
    end
`ifdef FIFO_ARB_STATS_EN
    compared++;
    if (pkt_count !== '0) begin
      mismatched++;
      $display("FAIL reset_pkt_count: got %h want 0", pkt_count);
    end
`endif
    idle_in();
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    do_reset();
    bus.in_valid = 4'b0001;
    set_beat(0, 8'hA1, 1'b0);
    #1;
    compared++;
    if (bus.in_ready !== 4'b0001) begin
      mismatched++;
      $display("FAIL single_rdy: got %b want 0001", bus.in_ready);
    end
    for (int b = 0; b < 3; b++) begin
      tick();
      compared++;
      if ({bus.out_valid, bus.out_data, locked, grant_id} !== {1'b1, 8'(8'hA1 + b), (b < 2), 2'd0}) begin
        mismatched++;
        $display("FAIL single_beat%0d: got v=%b d=%h l=%b g=%0d want 1 %h %b 0",
                 b, bus.out_valid, bus.out_data, locked, grant_id, 8'(8'hA1 + b), (b < 2));
      end
      set_beat(0, 8'(8'hA2 + b), (b == 1));
    end
    // rr_ptr now 1: with req0 and req1 both valid, req1 must win.
    bus.in_valid = 4'b0011;
    set_beat(1, 8'h5A, 1'b1);
    #1;
    compared++;
    if (bus.in_ready !== 4'b0010) begin
      mismatched++;
      $display("FAIL single_rr_next: got %b want 0010", bus.in_ready);
    end
    idle_in();
    tick();
  endtask

  task automatic test_fairness;
    do_reset();
    bus.in_valid = 4'b1111;
    bus.in_last  = 4'b1111;
    for (int r = 0; r < NR; r++) set_beat(r, 8'(8'h10 + r), 1'b1);
    #1;
    for (int k = 0; k < 6; k++) begin
      compared++;
      if (bus.in_ready !== 4'(1 << (k % 4))) begin
        mismatched++;
        $display("FAIL fair_rdy%0d: got %b want %b", k, bus.in_ready, 4'(1 << (k % 4)));
      end
      tick();
      compared++;
      if ({grant_id, bus.out_valid, bus.out_data, locked} !== {2'(k % 4), 1'b1, 8'(8'h10 + k % 4), 1'b0}) begin
        mismatched++;
        $display("FAIL fair_grant%0d: got g=%0d v=%b d=%h l=%b want %0d 1 %h 0",
                 k, grant_id, bus.out_valid, bus.out_data, locked, k % 4, 8'(8'h10 + k % 4));
      end
    end
`ifdef FIFO_ARB_STATS_EN
    compared++;
    if (pkt_count !== {16'd1, 16'd1, 16'd2, 16'd2}) begin
      mismatched++;
      $display("FAIL fair_pkt_count: got %h want 0001000100020002", pkt_count);
    end
`endif
    idle_in();
    tick();
  endtask

  task automatic test_atomicity;
    do_reset();
    bus.in_valid = 4'b0101;
    set_beat(0, 8'hB0, 1'b0);
    set_beat(2, 8'hC0, 1'b1);
    #1;
    compared++;
    if (bus.in_ready !== 4'b0001) begin
      mismatched++;
      $display("FAIL atom_first: got %b want 0001", bus.in_ready);
    end
    tick();
    set_beat(0, 8'hB1, 1'b0);
    tick();
    compared++;
    if ({bus.out_valid, bus.out_data, locked, grant_id} !== {1'b1, 8'hB1, 1'b1, 2'd0}) begin
      mismatched++;
      $display("FAIL atom_b1: got v=%b d=%h l=%b g=%0d want 1 b1 1 0",
               bus.out_valid, bus.out_data, locked, grant_id);
    end
    bus.in_valid = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      tick();
      compared++;
      if ({bus.in_ready, bus.out_valid, locked} !== {4'b0001, 1'b0, 1'b1}) begin
        mismatched++;
        $display("FAIL atom_gap%0d: got rdy=%b v=%b l=%b want 0001 0 1",
                 c, bus.in_ready, bus.out_valid, locked);
      end
    end
    bus.in_valid = 4'b0101;
    set_beat(0, 8'hB2, 1'b0);
    tick();
    set_beat(0, 8'hB3, 1'b1);
    tick();
    // Fourth beat is both last and at the limit: normal release, no error.
    compared++;
    if ({bus.out_valid, bus.out_data, locked, err_timeout} !== {1'b1, 8'hB3, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL atom_last: got v=%b d=%h l=%b e=%b want 1 b3 0 0",
               bus.out_valid, bus.out_data, locked, err_timeout);
    end
    compared++;
    if (bus.in_ready !== 4'b0100) begin
      mismatched++;
      $display("FAIL atom_req2_rdy: got %b want 0100", bus.in_ready);
    end
    bus.in_valid = 4'b0100;
    tick();
    compared++;
    if ({grant_id, bus.out_data, locked} !== {2'd2, 8'hC0, 1'b0}) begin
      mismatched++;
      $display("FAIL atom_req2_grant: got g=%0d d=%h l=%b want 2 c0 0",
               grant_id, bus.out_data, locked);
    end
    idle_in();
    tick();
  endtask

  task automatic test_backpressure;
    do_reset();
    bus.in_valid = 4'b1000;
    set_beat(3, 8'hD0, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    set_beat(3, 8'hD1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      compared++;
      if ({bus.out_valid, bus.out_data, bus.in_ready, locked} !== {1'b1, 8'hD0, 4'b0000, 1'b1}) begin
        mismatched++;
        $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b l=%b want 1 d0 0000 1",
                 c, bus.out_valid, bus.out_data, bus.in_ready, locked);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    compared++;
    if (bus.in_ready !== 4'b1000) begin
      mismatched++;
      $display("FAIL bp_resume_rdy: got %b want 1000", bus.in_ready);
    end
    tick();
    compared++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'hD1}) begin
      mismatched++;
      $display("FAIL bp_d1: got v=%b d=%h want 1 d1", bus.out_valid, bus.out_data);
    end
    set_beat(3, 8'hD2, 1'b1);
    tick();
    compared++;
    if ({bus.out_valid, bus.out_data, locked} !== {1'b1, 8'hD2, 1'b0}) begin
      mismatched++;
      $display("FAIL bp_d2: got v=%b d=%h l=%b want 1 d2 0", bus.out_valid, bus.out_data, locked);
    end
    idle_in();
    tick();
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_drain: got v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    bus.in_valid = 4'b0010;
    for (int b = 0; b < 4; b++) begin
      set_beat(1, 8'(8'hE0 + b), 1'b0);
      tick();
      compared++;
      if ({bus.out_data, err_timeout, locked} !== {8'(8'hE0 + b), (b == 3), (b < 3)}) begin
        mismatched++;
        $display("FAIL to_beat%0d: got d=%h e=%b l=%b want %h %b %b",
                 b, bus.out_data, err_timeout, locked, 8'(8'hE0 + b), (b == 3), (b < 3));
      end
    end
    set_beat(1, 8'hE4, 1'b0);
    #1;
    compared++;
    if (bus.in_ready !== 4'b0010) begin
      mismatched++;
      $display("FAIL to_regrant_rdy: got %b want 0010", bus.in_ready);
    end
    tick();
    compared++;
    if ({bus.out_data, err_timeout, locked, grant_id} !== {8'hE4, 1'b0, 1'b1, 2'd1}) begin
      mismatched++;
      $display("FAIL to_e4: got d=%h e=%b l=%b g=%0d want e4 0 1 1",
               bus.out_data, err_timeout, locked, grant_id);
    end
    set_beat(1, 8'hE5, 1'b1);
    tick();
    compared++;
    if ({bus.out_data, err_timeout, locked} !== {8'hE5, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL to_e5: got d=%h e=%b l=%b want e5 0 0", bus.out_data, err_timeout, locked);
    end
    idle_in();
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.in_valid = 4'b0010;
    set_beat(1, 8'hF9, 1'b1);
    tick();
    bus.in_valid = 4'b0100;
    set_beat(2, 8'hF0, 1'b0);
    tick();
    set_beat(2, 8'hF1, 1'b0);
    tick();
    compared++;
    if ({grant_id, locked, bus.out_valid, bus.out_data} !== {2'd2, 1'b1, 1'b1, 8'hF1}) begin
      mismatched++;
      $display("FAIL rm_pre: got g=%0d l=%b v=%b d=%h want 2 1 1 f1",
               grant_id, locked, bus.out_valid, bus.out_data);
    end
    set_beat(2, 8'hF2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({bus.out_valid, locked, grant_id, err_timeout, bus.in_ready} !== 9'h0) begin
      mismatched++;
      $display("FAIL rm_async: got v=%b l=%b g=%0d e=%b rdy=%b want all zero",
               bus.out_valid, locked, grant_id, err_timeout, bus.in_ready);
    end
`ifdef FIFO_ARB_STATS_EN
    compared++;
    if (pkt_count !== '0) begin
      mismatched++;
      $display("FAIL rm_pkt_count: got %h want 0", pkt_count);
    end
`endif
    bus.in_valid = 4'b0110;
    set_beat(1, 8'hF8, 1'b1);
    #2 rst_n = 1'b1;
    #1;
    compared++;
    if (bus.in_ready !== 4'b0010) begin
      mismatched++;
      $display("FAIL rm_first_rdy: got %b want 0010", bus.in_ready);
    end
    tick();
    compared++;
    if ({grant_id, bus.out_valid, bus.out_data} !== {2'd1, 1'b1, 8'hF8}) begin
      mismatched++;
      $display("FAIL rm_first_grant: got g=%0d v=%b d=%h want 1 1 f8",
               grant_id, bus.out_valid, bus.out_data);
    end
    idle_in();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_atomicity();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin, packet-atomic arbiter that shares the write port of one async_fifo instance among NUM_REQ requesters, all in the FIFO write clock domain. Each requester presents a valid/ready/last stream. The arbiter grants one requester for a whole packet and drives a registered single-beat output stage into the FIFO's w_valid/w_data/w_ready port. A beat-count watchdog releases a grant held by a runaway packet.

Parameters:
DATA_WIDTH, 8, beat width; matches FIFO DATA_WIDTH.
NUM_REQ, 4, number of requesters, 2..16.
MAX_BEATS, 64, maximum beats per packet before forced release, >=1.
ID_WIDTH, $clog2(NUM_REQ), width of the grant index (localparam).

Ports:
clk  input  1  single clock (FIFO write clock)
rst_n  input  1  asynchronous active-low reset
in_valid  input  NUM_REQ  per-requester beat valid
in_last  input  NUM_REQ  per-requester last beat of packet
in_data  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
in_ready  output  NUM_REQ  per-requester beat accepted
out_valid  output  1  to FIFO w_valid
out_data  output  DATA_WIDTH  to FIFO w_data
out_ready  input  1  from FIFO w_ready
grant_id  output  ID_WIDTH  current or last owner
locked  output  1  packet in progress
err_timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Clock and reset: clk only; rst_n is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, in_ready=0, grant_id=0, locked=0, err_timeout=0, rr pointer=0, beat count=0, state=IDLE.
- Output stage:
  - One register.
  - stage_free = !out_valid || out_ready.
  - in_ready[i] = (i == owner) && stage_free && (state==LOCKED, or the IDLE-cycle choice is i). All other bits are 0, so at most one bit is ever high.
  - Accepted beat (in_valid[owner] && in_ready[owner]) loads out_data and sets out_valid=1 on the next edge.
  - If out_ready=1 and nothing is accepted, out_valid clears.
  - Latency: input to out_valid is 1 cycle. Full throughput: one beat per cycle while out_ready=1.
- State machine:
  - IDLE:
    - Combinationally pick the first i with in_valid[i] searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
    - If stage_free and a winner exists: accept its beat the same cycle and set grant_id=i.
    - If the beat has in_last=1: stay IDLE, rr_ptr <= i+1 mod NUM_REQ.
    - Otherwise: go to LOCKED, locked=1, beat count=1.
    - No valid, or stage not free: no change.
  - LOCKED:
    - Only grant_id may transfer. Other requesters wait regardless of owner idle cycles.
    - Each accepted beat increments the beat count.
    - Accepted beat with in_last=1: go to IDLE, locked=0, rr_ptr <= grant_id+1, count=0.
    - Accepted non-last beat with count==MAX_BEATS-1: forced release. Go to IDLE, err_timeout=1 for one cycle, rr_ptr advances. The beat is still delivered.
- Simultaneous events: a beat that is both last and at the timeout limit is a normal release, with no err_timeout.
- MAX_BEATS=1: every beat releases; a non-last beat also pulses err_timeout.
- Backpressure:
  - out_ready=0 with out_valid=1 holds out_data stable, and all in_ready are 0.
  - Data is never dropped or duplicated.
- rr_ptr wrap: after NUM_REQ-1 it wraps to 0.
- Reset mid-packet: everything returns to reset values immediately. Any beat in the output stage is discarded. The downstream FIFO is reset separately.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - Adds output pkt_count, NUM_REQ*16 bits, with requester i at [i*16 +: 16].
  - Each counter increments on every release of requester i's grant, whether normal or forced, and wraps at 16'hFFFF->0.
  - Counters reset to 0.
- Undefined: the port and counters are absent. All other behaviour is identical.

Test Plan:
- Single requester: in_valid=4'b0001, 3-beat packet 0xA1,0xA2,0xA3 with last on 3rd, out_ready=1 -> out_data 0xA1..0xA3 on cycles 1..3, locked high cycles 1-2, rr_ptr=1 after.
- Fairness: all four requesters continuously send 1-beat packets, out_ready=1 -> grant_id sequence 0,1,2,3,0,1, one beat per cycle.
- Atomicity: req0 starts a 4-beat packet, then drops in_valid for 2 cycles mid-packet while req2 is valid -> req2 in_ready stays 0 until req0's last beat; req2 granted the cycle after.
- Backpressure: out_ready=0 for 5 cycles during a packet -> out_valid=1, out_data unchanged, in_ready=0; resumes with no loss and no duplicate.
- Timeout: MAX_BEATS=4, req1 sends 6 beats with no last -> 4th beat delivered, err_timeout pulses once, locked=0; req1's remaining 2 beats re-arbitrate as a new packet.
- Reset mid-packet: assert rst_n=0 during beat 2 of 5 -> out_valid=0, locked=0, grant_id=0 asynchronously; after release the first grant goes to the lowest valid requester. With FIFO_ARB_STATS_EN defined, counters read 0.
